bin_to_bcd8: RTL and testbench

BIN_TO_BCD8 -- requirements
Module: bin_to_bcd8

---
 rtl/display_pkg.sv | 18 +
 rtl/bcd_digit_adjust.sv | 17 +
 rtl/bin_to_bcd8.sv | 121 ++++++++++++
 tb/tb_bin_to_bcd8.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display constants and the binary-to-BCD converter state encoding.
//   NUM_DIGITS  : number of packed BCD digits driven to the hex display
//   MAX_DEC     : largest value representable in NUM_DIGITS decimal digits
//   ERR_PATTERN : digit pattern shown when the value does not fit
//   state_t     : converter FSM states
package display_pkg;

  localparam int          NUM_DIGITS  = 8;
  localparam int unsigned MAX_DEC     = 99_999_999;
  localparam logic [31:0] ERR_PATTERN = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble per-digit correction: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
//   i_digit : 4-bit BCD digit before correction
//   o_digit : 4-bit corrected digit (no carry out to the neighbouring digit)
module bcd_digit_adjust (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  always_comb begin
    o_digit = i_digit;
    if (i_digit >= 4'd5) begin
      o_digit = i_digit + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd8.sv
// Sequential binary-to-packed-BCD converter (double-dabble) feeding an
// 8-digit hex display. Fixed latency of BIN_W+1 cycles after accept; results
// are held in output registers so the display never sees partial digits.
//   clk_in       : system clock
//   rst_in       : synchronous active-high reset
//   start_in     : convert value_in (accepted only while ready_out=1)
//   value_in     : unsigned binary value, sampled on accept
//   ready_out    : idle, able to accept start_in
//   done_out     : one-cycle pulse when bcd_out/overflow_out update
//   bcd_out      : packed BCD, most significant digit in the MSBs
//   overflow_out : last accepted value exceeded MAX_DEC
module bin_to_bcd8
  import display_pkg::*;
#(
  parameter int BIN_W      = 27,
  parameter int NUM_DIGITS = display_pkg::NUM_DIGITS
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [BIN_W-1:0]        value_in,
  output logic                    ready_out,
  output logic                    done_out,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_work;
  logic [BCD_W-1:0]   w_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf_work;
  logic [BCD_W-1:0]   r_bcd;
  logic               r_ovf;
  logic               r_done;
  logic               w_ready;
  logic               w_load;
  logic               w_shift;
  logic               w_finish;
  logic               w_last_shift;

  assign w_last_shift = (r_cnt == CNT_W'(BIN_W - 1));

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start_in)     w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last_shift) w_state_nxt = ST_DONE;
      ST_DONE:                    w_state_nxt = ST_IDLE;
      default:                    w_state_nxt = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_ready  = (r_state == ST_IDLE);
    w_load   = w_ready && start_in;
    w_shift  = (r_state == ST_SHIFT);
    w_finish = (r_state == ST_DONE);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit (r_work[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // Datapath: the overflow decision is taken on accept so the shift chain can
  // run unchanged; the error pattern replaces the digits only when published.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_bin      <= '0;
      r_work     <= '0;
      r_cnt      <= '0;
      r_ovf_work <= 1'b0;
      r_bcd      <= '0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_bin      <= value_in;
        r_work     <= '0;
        r_cnt      <= '0;
        r_ovf_work <= (64'(value_in) > 64'(MAX_DEC));
      end
      if (w_shift) begin
        r_work <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
        r_bin  <= r_bin << 1;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (w_finish) begin
        r_bcd  <= r_ovf_work ? BCD_W'(ERR_PATTERN) : r_work;
        r_ovf  <= r_ovf_work;
        r_done <= 1'b1;
      end
    end
  end

  assign ready_out    = w_ready;
  assign done_out     = r_done;
  assign bcd_out      = r_bcd;
  assign overflow_out = r_ovf;

endmodule

// File: tb/tb_bin_to_bcd8.sv
module tb_bin_to_bcd8;

  localparam int BIN_W   = 27;
  localparam int LATENCY = BIN_W + 1;
  localparam int LIMIT   = 40;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              start_in;
  logic [BIN_W-1:0]  value_in;
  logic              ready_out;
  logic              done_out;
  logic [31:0]       bcd_out;
  logic              overflow_out;

  int n_checks = 0;
  int n_errors = 0;

  bin_to_bcd8 #(.BIN_W(BIN_W), .NUM_DIGITS(8)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .start_in     (start_in),
    .value_in     (value_in),
    .ready_out    (ready_out),
    .done_out     (done_out),
    .bcd_out      (bcd_out),
    .overflow_out (overflow_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, error pattern above 8 digits.
  function automatic logic [31:0] ref_bcd(input longint unsigned v);
    logic [31:0] r;
    longint unsigned t;
    r = '0;
    if (v > 64'd99_999_999) return 32'hFFFF_FFFF;
    t = v;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Starts a conversion at the next edge; optionally pulses a stray start
  // with value 7 'glitch' cycles after accept. Returns at the done cycle.
  task automatic convert(input string tag, input logic [BIN_W-1:0] v, input int glitch);
    int lat;
    logic got;
    logic held;
    logic [31:0] prev;
    prev = bcd_out;
    held = 1'b1;
    check_eq({tag, "_ready"}, 64'(ready_out), 64'd1);
    start_in = 1'b1;
    value_in = v;
    tick();
    start_in = 1'b0;
    value_in = BIN_W'($urandom);
    lat = 0;
    got = 1'b0;
    while (lat < LIMIT && !got) begin
      if (lat == glitch) begin
        check_eq({tag, "_busy"}, 64'(ready_out), 64'd0);
        start_in = 1'b1;
        value_in = BIN_W'(7);
      end
      tick();
      start_in = 1'b0;
      lat++;
      got = done_out;
      if (!got && bcd_out !== prev) held = 1'b0;
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(LATENCY));
    check_eq({tag, "_hold"}, 64'(held), 64'd1);
    check_eq({tag, "_bcd"}, 64'(bcd_out), 64'(ref_bcd(64'(v))));
    check_eq({tag, "_ovf"}, 64'(overflow_out), 64'(v > BIN_W'(99_999_999)));
  endtask

  task automatic count_dones(input string tag, input int cycles, input int exp);
    int n;
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done_out) n++;
    end
    check_eq(tag, 64'(n), 64'(exp));
  endtask

  initial begin
    rst_in   = 1'b1;
    start_in = 1'b0;
    value_in = '0;
    tick();
    tick();
    rst_in = 1'b0;
    check_eq("rst_ready", 64'(ready_out), 64'd1);
    check_eq("rst_done", 64'(done_out), 64'd0);
    check_eq("rst_bcd", 64'(bcd_out), 64'd0);
    check_eq("rst_ovf", 64'(overflow_out), 64'd0);

    convert("zero", BIN_W'(0), -1);
    tick();

    convert("b2b_a", BIN_W'(12_345_678), -1);
    convert("b2b_b", BIN_W'(99_999_999), -1);
    tick();

    convert("ovf", BIN_W'(100_000_000), -1);
    convert("nine", BIN_W'(9), -1);
    convert("max27", BIN_W'((1 << 27) - 1), -1);
    tick();

    convert("glitch", BIN_W'(4_095), 10);
    count_dones("glitch_single", 35, 0);

    // Reset 15 cycles into a conversion, with start held high in the reset cycle.
    start_in = 1'b1;
    value_in = BIN_W'(55_555_555);
    tick();
    start_in = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    rst_in   = 1'b1;
    start_in = 1'b1;
    value_in = BIN_W'(3);
    tick();
    rst_in   = 1'b0;
    start_in = 1'b0;
    check_eq("mrst_ready", 64'(ready_out), 64'd1);
    check_eq("mrst_bcd", 64'(bcd_out), 64'd0);
    check_eq("mrst_done", 64'(done_out), 64'd0);
    count_dones("mrst_nodone", 35, 0);

    for (int k = 0; k < 40; k++) begin
      logic [BIN_W-1:0] rv;
      case (k % 4)
        0:       rv = BIN_W'($urandom_range(0, 999));
        1:       rv = BIN_W'($urandom_range(99_999_990, 100_000_010));
        default: rv = BIN_W'($urandom_range(0, (1 << 27) - 1));
      endcase
      convert("rand", rv, -1);
      if (k % 3 == 0) tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
